// File: rtl/fetch_pkg.sv
// Shared widths, constants and the queue entry payload for the instruction-fetch stage.
package fetch_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned INST_W = 32;

    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [XLEN-1:0]   pc;
    } fetch_entry_t;

    // Clear the byte-offset bits so every fetch address is word aligned
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO of fetched instructions with synchronous flush; head is a read of the
// entry at the read pointer.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter  int unsigned QDEPTH = 4,
    localparam int unsigned AW     = $clog2(QDEPTH),
    localparam int unsigned CW     = AW + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head_c,
    output logic [CW-1:0] count
);

    fetch_entry_t    mem [QDEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < QDEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head_c = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC generation, credit-limited memory requests, in-order
// response capture with redirect-time discard of stale responses, and decode handshake.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned     QDEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [XLEN-1:0]   imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [XLEN-1:0]   inst_pc
);

    localparam int unsigned CW = $clog2(QDEPTH) + 1;
    localparam int unsigned SW = CW + 1;

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] rsp_pc_q;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   q_count;

    logic            credit_c;
    logic            req_fire_c;
    logic            enq_c;
    logic            deq_c;
    fetch_entry_t    enq_entry_c;
    fetch_entry_t    head_c;

    // Every queued or in-flight instruction holds one queue slot, so responses never overflow
    assign credit_c       = (SW'(q_count) + SW'(outstanding)) < SW'(QDEPTH);
    assign imem_req_valid = !rst && credit_c && !redirect_valid;
    assign imem_req_addr  = pc_q;
    assign req_fire_c     = imem_req_valid && imem_req_ready;

    assign enq_c          = imem_rsp_valid && !redirect_valid && (drop_cnt == '0);
    assign enq_entry_c    = '{inst: imem_rsp_data, pc: rsp_pc_q};

    assign inst_valid     = (q_count != '0) && !redirect_valid;
    assign deq_c          = inst_valid && inst_ready;
    assign inst           = head_c.inst;
    assign inst_pc        = head_c.pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            rsp_pc_q    <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding + CW'(req_fire_c) - CW'(imem_rsp_valid);
            if (redirect_valid) begin
                // Everything still in flight belongs to the abandoned path
                pc_q     <= word_align(redirect_pc);
                rsp_pc_q <= word_align(redirect_pc);
                drop_cnt <= outstanding - CW'(imem_rsp_valid);
            end else begin
                if (req_fire_c) begin
                    pc_q <= pc_q + PC_STEP;
                end
                if (enq_c) begin
                    rsp_pc_q <= rsp_pc_q + PC_STEP;
                end
                if (imem_rsp_valid && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - CW'(1);
                end
            end
        end
    end

    fetch_queue #(
        .QDEPTH (QDEPTH)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .push       (enq_c),
        .push_entry (enq_entry_c),
        .pop        (deq_c),
        .flush      (redirect_valid),
        .head_c     (head_c),
        .count      (q_count)
    );

    rsp_needs_request: assert property (
        @(posedge clk) disable iff (rst) imem_rsp_valid |-> (outstanding != '0)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed per-cycle vector table plus randomized traffic checked
// against a queue-level model of requests in flight and instructions awaiting decode.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h100;
    localparam int          QDEPTH   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc)
    );

    // Model: requests in flight (with a stale mark) and instructions waiting for decode
    typedef struct { logic [31:0] addr; bit stale; } req_t;
    typedef struct { logic [31:0] data; logic [31:0] pc; } ent_t;
    req_t        mq[$];
    ent_t        iq[$];
    logic [31:0] fpc;

    bit          m_rv;
    bit          m_iv;
    logic [31:0] m_addr;
    ent_t        m_head;

    typedef struct {
        bit rr; bit ir; bit re; bit rd; logic [31:0] rpc;
        bit erv; logic [31:0] eaddr; bit eiv; logic [31:0] eipc;
    } vec_t;
    vec_t vt[25];

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic vec_t row(input bit rr, input bit ir, input bit re, input bit rd,
                                 input logic [31:0] rpc, input bit erv, input logic [31:0] ea,
                                 input bit eiv, input logic [31:0] ep);
        vec_t v;
        v.rr = rr; v.ir = ir; v.re = re; v.rd = rd; v.rpc = rpc;
        v.erv = erv; v.eaddr = ea; v.eiv = eiv; v.eipc = ep;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge and form the model's predictions
    task automatic apply(input bit rr, input bit ir, input bit re, input bit rd,
                         input logic [31:0] rpc);
        @(negedge clk);
        imem_req_ready = rr;
        inst_ready     = ir;
        redirect_valid = rd;
        redirect_pc    = rpc;
        if (re && mq.size() != 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memfn(mq[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        m_rv   = (iq.size() + mq.size() < QDEPTH) && !rd;
        m_addr = fpc;
        m_iv   = (iq.size() != 0) && !rd;
        if (iq.size() != 0) m_head = iq[0];
        #1;
    endtask

    task automatic commit();
        req_t r;
        if (redirect_valid) begin
            iq.delete();
            if (imem_rsp_valid) r = mq.pop_front();
            foreach (mq[i]) mq[i].stale = 1'b1;
            fpc = redirect_pc & ~32'd3;
        end else begin
            if (m_iv && inst_ready) void'(iq.pop_front());
            if (imem_rsp_valid) begin
                r = mq.pop_front();
                if (!r.stale) iq.push_back('{memfn(r.addr), r.addr});
            end
            if (m_rv && imem_req_ready) begin
                mq.push_back('{fpc, 1'b0});
                fpc = fpc + 32'd4;
            end
        end
    endtask

    task automatic check_model();
        chk("req_valid", 32'(imem_req_valid), 32'(m_rv));
        if (m_rv) chk("req_addr", imem_req_addr, m_addr);
        chk("inst_valid", 32'(inst_valid), 32'(m_iv));
        if (m_iv) begin
            chk("inst", inst, m_head.data);
            chk("inst_pc", inst_pc, m_head.pc);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        iq.delete();
        fpc = RESET_PC;
    endtask

    task automatic random_cycles(input int n);
        bit rd;
        logic [31:0] rpc;
        for (int i = 0; i < n; i++) begin
            rd  = ($urandom_range(0, 19) == 0);
            rpc = $urandom;
            if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFE0 | (rpc & 32'h1F);
            apply(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 3) != 0), rd, rpc);
            check_model();
            commit();
        end
    endtask

    initial begin
        // Hand-derived cycle table: streaming, backpressure, redirect with drops,
        // redirect colliding with a response and a dequeue
        vt[0]  = row(1, 1, 1, 0, 32'h0,   1, 32'h100, 0, 32'h0);
        vt[1]  = row(1, 1, 1, 0, 32'h0,   1, 32'h104, 0, 32'h0);
        vt[2]  = row(1, 1, 1, 0, 32'h0,   1, 32'h108, 1, 32'h100);
        vt[3]  = row(1, 1, 1, 0, 32'h0,   1, 32'h10C, 1, 32'h104);
        vt[4]  = row(1, 1, 1, 0, 32'h0,   1, 32'h110, 1, 32'h108);
        vt[5]  = row(1, 0, 1, 0, 32'h0,   1, 32'h114, 1, 32'h10C);
        vt[6]  = row(1, 0, 1, 0, 32'h0,   1, 32'h118, 1, 32'h10C);
        vt[7]  = row(1, 0, 1, 0, 32'h0,   0, 32'h0,   1, 32'h10C);
        vt[8]  = row(1, 0, 1, 0, 32'h0,   0, 32'h0,   1, 32'h10C);
        vt[9]  = row(1, 1, 1, 0, 32'h0,   0, 32'h0,   1, 32'h10C);
        vt[10] = row(1, 1, 1, 0, 32'h0,   1, 32'h11C, 1, 32'h110);
        vt[11] = row(1, 1, 1, 0, 32'h0,   1, 32'h120, 1, 32'h114);
        vt[12] = row(1, 1, 1, 0, 32'h0,   1, 32'h124, 1, 32'h118);
        vt[13] = row(1, 1, 1, 0, 32'h0,   1, 32'h128, 1, 32'h11C);
        vt[14] = row(1, 1, 0, 0, 32'h0,   1, 32'h12C, 1, 32'h120);
        vt[15] = row(1, 1, 0, 1, 32'h203, 0, 32'h0,   0, 32'h0);
        vt[16] = row(1, 1, 1, 0, 32'h0,   1, 32'h200, 0, 32'h0);
        vt[17] = row(1, 1, 1, 0, 32'h0,   1, 32'h204, 0, 32'h0);
        vt[18] = row(1, 1, 1, 0, 32'h0,   1, 32'h208, 0, 32'h0);
        vt[19] = row(1, 1, 1, 0, 32'h0,   1, 32'h20C, 1, 32'h200);
        vt[20] = row(1, 1, 1, 0, 32'h0,   1, 32'h210, 1, 32'h204);
        vt[21] = row(1, 1, 1, 1, 32'h300, 0, 32'h0,   0, 32'h0);
        vt[22] = row(1, 1, 1, 0, 32'h0,   1, 32'h300, 0, 32'h0);
        vt[23] = row(1, 1, 1, 0, 32'h0,   1, 32'h304, 0, 32'h0);
        vt[24] = row(1, 1, 1, 0, 32'h0,   1, 32'h308, 1, 32'h300);

        rst            = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b0;
        model_reset();

        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
        chk("rst_inst_valid", 32'(inst_valid), 32'h0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);

        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("first_req_valid", 32'(imem_req_valid), 32'h1);
        chk("first_req_addr", imem_req_addr, RESET_PC);
        chk("first_inst_valid", 32'(inst_valid), 32'h0);

        for (int i = 0; i < 25; i++) begin
            apply(vt[i].rr, vt[i].ir, vt[i].re, vt[i].rd, vt[i].rpc);
            chk($sformatf("vec%0d_req_valid", i), 32'(imem_req_valid), 32'(vt[i].erv));
            if (vt[i].erv) chk($sformatf("vec%0d_req_addr", i), imem_req_addr, vt[i].eaddr);
            chk($sformatf("vec%0d_inst_valid", i), 32'(inst_valid), 32'(vt[i].eiv));
            if (vt[i].eiv) begin
                chk($sformatf("vec%0d_inst_pc", i), inst_pc, vt[i].eipc);
                chk($sformatf("vec%0d_inst", i), inst, memfn(vt[i].eipc));
            end
            commit();
        end

        random_cycles(3000);

        // Fill the queue, leave requests outstanding, then reset mid-flight
        for (int i = 0; i < 6; i++) begin
            apply(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
            check_model();
            commit();
        end
        for (int i = 0; i < 2; i++) begin
            apply(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
            check_model();
            commit();
        end

        @(negedge clk);
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        inst_ready     = 1'b0;
        #1;
        chk("midrst_req_valid", 32'(imem_req_valid), 32'h0);
        chk("midrst_inst_valid", 32'(inst_valid), 32'h0);
        chk("midrst_inst", inst, 32'h0);
        chk("midrst_inst_pc", inst_pc, 32'h0);
        model_reset();

        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("restart_req_valid", 32'(imem_req_valid), 32'h1);
        chk("restart_req_addr", imem_req_addr, RESET_PC);
        chk("restart_inst_valid", 32'(inst_valid), 32'h0);

        random_cycles(500);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
